// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state type and op classification for the multi-cycle EX-stage ALU.
package seq_alu_pkg;

  localparam logic [3:0] OP_SLL  = 4'd0;
  localparam logic [3:0] OP_SRA  = 4'd1;
  localparam logic [3:0] OP_SRL  = 4'd2;
  localparam logic [3:0] OP_MULU = 4'd3;
  localparam logic [3:0] OP_DIVU = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_NOR  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_SLTU = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;
  localparam logic [3:0] OP_DIV  = 4'd14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv_iter.sv
// Radix-2 iterative multiply (shift-add) and restoring divide on magnitudes, with sign fix-up.
module muldiv_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic             o_last
);

  localparam int CW = $clog2(WIDTH);

  logic             r_run;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic             r_div;
  logic             r_neg_lo;
  logic             r_neg_hi;

  logic             w_signed;
  logic             w_ldiv;
  logic [WIDTH-1:0] w_ax;
  logic [WIDTH-1:0] w_ay;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_acc_n;
  logic [WIDTH-1:0] w_q_n;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_f;

  assign w_signed = (i_op == OP_MUL) || (i_op == OP_DIV);
  assign w_ldiv   = (i_op == OP_DIVU) || (i_op == OP_DIV);
  assign w_ax     = (w_signed && i_x[WIDTH-1]) ? -i_x : i_x;
  assign w_ay     = (w_signed && i_y[WIDTH-1]) ? -i_y : i_y;

  always_comb begin
    w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    w_sh    = {r_acc, r_q[WIDTH-1]};
    w_ge    = (w_sh >= {1'b0, r_b});
    w_diff  = w_sh[WIDTH-1:0] - r_b;
    w_acc_n = w_sum[WIDTH:1];
    w_q_n   = {w_sum[0], r_q[WIDTH-1:1]};
    if (r_div) begin
      w_acc_n = w_ge ? w_diff : w_sh[WIDTH-1:0];
      w_q_n   = {r_q[WIDTH-2:0], w_ge};
    end
    w_prod   = {w_acc_n, w_q_n};
    w_prod_f = r_neg_lo ? -w_prod : w_prod;
  end

  // Results are the fixed-up view of the step being taken now, so the top can register them on the last step.
  assign o_lo   = r_div ? (r_neg_lo ? -w_q_n : w_q_n) : w_prod_f[WIDTH-1:0];
  assign o_hi   = r_div ? (r_neg_hi ? -w_acc_n : w_acc_n) : w_prod_f[2*WIDTH-1:WIDTH];
  assign o_last = r_run && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_b      <= '0;
      r_div    <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
    end else if (i_load) begin
      r_run    <= 1'b1;
      r_cnt    <= CW'(WIDTH - 1);
      r_acc    <= '0;
      r_q      <= w_ldiv ? w_ax : w_ay;
      r_b      <= w_ldiv ? w_ay : w_ax;
      r_div    <= w_ldiv;
      // A zero divisor must yield an all-ones quotient regardless of operand signs.
      r_neg_lo <= w_signed && (i_x[WIDTH-1] ^ i_y[WIDTH-1]) && !(w_ldiv && (i_y == '0));
      r_neg_hi <= w_signed && i_x[WIDTH-1];
    end else if (r_run) begin
      r_acc <= w_acc_n;
      r_q   <= w_q_n;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle EX-stage ALU with start/busy/done handshake; iterative mul/div in muldiv_iter.
// Define ALU_OVF_EN to add the o_ovf signed-overflow output for ADD/SUB.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_aluop,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic [SHW-1:0]   i_shamt,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_result2,
  output logic             o_equal,
`ifdef ALU_OVF_EN
  output logic             o_ovf,
`endif
  output logic [1:0]       o_state
);

  // Handshake: i_start is accepted only in IDLE; o_busy covers the iterative
  // cycles, o_done pulses one cycle with o_result/o_result2/o_equal valid from then on.
  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result2;
  logic             r_equal;
  logic             r_eq_cap;
  logic             r_ovf;

  logic             w_load;
  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_alu;
  logic             w_ovf;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  logic             w_last;

  assign w_load = (r_state == IDLE) && i_start && is_iter(i_aluop);
  assign w_add  = i_x + i_y;
  assign w_sub  = i_x - i_y;

  always_comb begin
    w_alu = '0;
    case (i_aluop)
      OP_SLL:  w_alu = i_y << i_shamt;
      OP_SRA:  w_alu = $signed(i_y) >>> i_shamt;
      OP_SRL:  w_alu = i_y >> i_shamt;
      OP_ADD:  w_alu = w_add;
      OP_SUB:  w_alu = w_sub;
      OP_AND:  w_alu = i_x & i_y;
      OP_OR:   w_alu = i_x | i_y;
      OP_XOR:  w_alu = i_x ^ i_y;
      OP_NOR:  w_alu = ~(i_x | i_y);
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(i_x) < $signed(i_y))};
      OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (i_x < i_y)};
      default: w_alu = '0;
    endcase
  end

  assign w_ovf = ((i_aluop == OP_ADD) && (i_x[WIDTH-1] == i_y[WIDTH-1]) && (w_add[WIDTH-1] != i_x[WIDTH-1])) ||
                 ((i_aluop == OP_SUB) && (i_x[WIDTH-1] != i_y[WIDTH-1]) && (w_sub[WIDTH-1] != i_x[WIDTH-1]));

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_op   (i_aluop),
    .i_x    (i_x),
    .i_y    (i_y),
    .o_lo   (w_lo),
    .o_hi   (w_hi),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_result2 <= '0;
      r_equal   <= 1'b0;
      r_eq_cap  <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start && is_iter(i_aluop)) begin
            r_state  <= CALC;
            r_busy   <= 1'b1;
            r_eq_cap <= (i_x == i_y);
          end else if (i_start) begin
            r_state   <= FIN;
            r_done    <= 1'b1;
            r_result  <= w_alu;
            r_result2 <= '0;
            r_equal   <= (i_x == i_y);
            r_ovf     <= w_ovf;
          end
        end
        CALC: begin
          if (w_last) begin
            r_state   <= FIN;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_result  <= w_lo;
            r_result2 <= w_hi;
            r_equal   <= r_eq_cap;
            r_ovf     <= 1'b0;
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_result  = r_result;
  assign o_result2 = r_result2;
  assign o_equal   = r_equal;
  assign o_state   = r_state;
`ifdef ALU_OVF_EN
  assign o_ovf     = r_ovf;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = r_ovf ^ w_ovf;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed cases plus randomized ops against a 64-bit arithmetic model.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W   = 32;
  localparam int SHW = 5;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_start = 1'b0;
  logic [3:0]     i_aluop = '0;
  logic [W-1:0]   i_x = '0;
  logic [W-1:0]   i_y = '0;
  logic [SHW-1:0] i_shamt = '0;
  logic           o_busy;
  logic           o_done;
  logic [W-1:0]   o_result;
  logic [W-1:0]   o_result2;
  logic           o_equal;
  logic [1:0]     o_state;
`ifdef ALU_OVF_EN
  logic           o_ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .i_aluop   (i_aluop),
    .i_x       (i_x),
    .i_y       (i_y),
    .i_shamt   (i_shamt),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_result  (o_result),
    .o_result2 (o_result2),
    .o_equal   (o_equal),
`ifdef ALU_OVF_EN
    .o_ovf     (o_ovf),
`endif
    .o_state   (o_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the operation definitions.
  function automatic void ref_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [SHW-1:0] sh, output logic [W-1:0] lo,
                                    output logic [W-1:0] hi, output logic ov);
    longint sa, sb, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lo = '0;
    hi = '0;
    ov = 1'b0;
    r  = 0;
    p  = '0;
    case (op)
      4'd0:  lo = b << sh;
      4'd1:  lo = $signed(b) >>> sh;
      4'd2:  lo = b >> sh;
      4'd3:  begin p = {32'd0, a} * {32'd0, b}; lo = p[31:0]; hi = p[63:32]; end
      4'd4:  begin
               if (b == 0) begin lo = '1; hi = a; end
               else begin lo = a / b; hi = a % b; end
             end
      4'd5:  begin r = sa + sb; lo = r[31:0]; ov = (r > MAXS) || (r < MINS); end
      4'd6:  begin r = sa - sb; lo = r[31:0]; ov = (r > MAXS) || (r < MINS); end
      4'd7:  lo = a & b;
      4'd8:  lo = a | b;
      4'd9:  lo = a ^ b;
      4'd10: lo = ~(a | b);
      4'd11: lo = {31'd0, (sa < sb)};
      4'd12: lo = {31'd0, (a < b)};
      4'd13: begin r = sa * sb; lo = r[31:0]; hi = r[63:32]; end
      4'd14: begin
               if (b == 0) begin lo = '1; hi = a; end
               else if (sa == MINS && sb == -1) begin lo = a; hi = '0; end
               else begin r = sa / sb; lo = r[31:0]; r = sa % sb; hi = r[31:0]; end
             end
      default: lo = '0;
    endcase
  endfunction

  // Driver + monitor: issues one op, scrambles inputs after acceptance, optionally pulses start at poke cycles.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [SHW-1:0] sh, input int poke1, input int poke2);
    logic [W-1:0] lo, hi, elo, ehi;
    logic ov;
    int lat, done_at, n_done, busy_bad;
    bit exp_busy;
    ref_model(op, a, b, sh, lo, hi, ov);
    exp_q.push_back(lo);
    exp_q.push_back(hi);
    lat = is_iter(op) ? W + 1 : 1;
    done_at = 0;
    n_done = 0;
    busy_bad = 0;
    @(negedge clk);
    i_start = 1'b1; i_aluop = op; i_x = a; i_y = b; i_shamt = sh;
    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clk);
      exp_busy = is_iter(op) && (k <= W);
      if (o_busy !== exp_busy) busy_bad++;
      if (o_done === 1'b1) begin
        n_done++;
        if (done_at == 0) begin
          done_at = k;
          elo = exp_q.pop_front();
          ehi = exp_q.pop_front();
          check_eq({tag, "_result"}, o_result, elo);
          check_eq({tag, "_result2"}, o_result2, ehi);
          check_eq({tag, "_equal"}, o_equal, (a == b));
`ifdef ALU_OVF_EN
          check_eq({tag, "_ovf"}, o_ovf, ov);
`endif
        end
      end
      i_start = (k == poke1) || (k == poke2);
      i_aluop = i_start ? OP_ADD : 4'($urandom_range(0, 15));
      i_x = $urandom;
      i_y = $urandom;
      i_shamt = SHW'($urandom);
    end
    i_start = 1'b0;
    if (done_at == 0) begin
      check_eq({tag, "_timeout"}, 0, 1);
      exp_q.delete();
    end
    check_eq({tag, "_latency"}, done_at, lat);
    check_eq({tag, "_pulses"}, n_done, 1);
    check_eq({tag, "_busy"}, busy_bad, 0);
  endtask

  initial begin
    logic [3:0] rop;
    logic [W-1:0] ra, rb;
    int bad;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_done", o_done, 0);
    check_eq("rst_result", o_result, 0);
    check_eq("rst_result2", o_result2, 0);
    check_eq("rst_equal", o_equal, 0);
    check_eq("rst_state", o_state, 0);
`ifdef ALU_OVF_EN
    check_eq("rst_ovf", o_ovf, 0);
`endif
    rst_n = 1'b1;

    run_op("add",  OP_ADD,  32'h05010301, 32'h52405760, 5'd0, 0, 0);
    run_op("sub",  OP_SUB,  32'h00001234, 32'h00001234, 5'd0, 0, 0);
    run_op("sll",  OP_SLL,  32'h0,        32'h52405760, 5'd4, 0, 0);
    run_op("sra",  OP_SRA,  32'h0,        32'h80000000, 5'd31, 0, 0);
    run_op("srl",  OP_SRL,  32'h0,        32'h80000000, 5'd31, 0, 0);
    run_op("rsvd", 4'd15,   32'h12345678, 32'h9abcdef0, 5'd3, 0, 0);
    run_op("mulu", OP_MULU, 32'hFFFFFFFF, 32'h2,        5'd0, 5, 32);
    run_op("mulu_fin", OP_MULU, 32'h00010001, 32'h00030003, 5'd0, W + 1, 0);
    run_op("mul",  OP_MUL,  32'hFFFFFFFD, 32'h5,        5'd0, 0, 0);
    run_op("div",  OP_DIV,  32'hFFFFFFF9, 32'h2,        5'd0, 0, 0);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd0, 0, 0);
    run_op("div_z", OP_DIV, 32'hFFFFFFF9, 32'h0,        5'd0, 0, 0);
    run_op("divu_z", OP_DIVU, 32'h00001234, 32'h0,      5'd0, 0, 0);
`ifdef ALU_OVF_EN
    run_op("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1,      5'd0, 0, 0);
    run_op("add_novf", OP_ADD, 32'h1,       32'h1,      5'd0, 0, 0);
    run_op("sub_ovf", OP_SUB, 32'h80000000, 32'h1,      5'd0, 0, 0);
`endif

    // Reset in the middle of a DIV: outputs clear at once and no done follows.
    @(negedge clk);
    i_start = 1'b1; i_aluop = OP_DIV; i_x = 32'h00000064; i_y = 32'h00000007; i_shamt = '0;
    @(negedge clk);
    i_start = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("rst_mid_busy_before", o_busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_busy", o_busy, 0);
    check_eq("rst_mid_done", o_done, 0);
    check_eq("rst_mid_result", o_result, 0);
    check_eq("rst_mid_result2", o_result2, 0);
    check_eq("rst_mid_state", o_state, 0);
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (o_done !== 1'b0 || o_busy !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (o_done !== 1'b0 || o_busy !== 1'b0) bad++;
    end
    check_eq("rst_mid_quiet", bad, 0);
    run_op("add_after_rst", OP_ADD, 32'h00000010, 32'h00000020, 5'd0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h80000000; rb = '1; end
        2: rb = ra;
        3: begin ra = W'($urandom_range(0, 255)); rb = W'($urandom_range(1, 15)); end
        default: ;
      endcase
      run_op($sformatf("rnd%0d_op%0d", n, rop), rop, ra, rb, SHW'($urandom), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle CPU ALU.
- Executes the same 4-bit aluop set. Adds an iterative multiply/divide unit, with `result` = LO and `result2` = HI (or remainder).
- Uses a start/busy/done handshake so the pipeline can stall on long ops.
- Sits in the EX stage between operand muxes and EX/MEM register.

Parameters:
- WIDTH, 32, datapath width in bits; must be ≥ 4 and a power of 2.
- SHW, $clog2(WIDTH), shamt width; localparam derived from WIDTH, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  op request; accepted only in IDLE
- aluop  in  4  operation code (see Behaviour)
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B (shift source for shifts)
- shamt  in  SHW  shift amount
- busy  out  1  high while an iterative op is in progress
- done  out  1  one-cycle pulse; results valid from this cycle
- result  out  WIDTH  main result / LO / quotient
- result2  out  WIDTH  HI / remainder; 0 for single-cycle ops
- equal  out  1  (x == y), captured at acceptance

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, result, result2, equal (and ovf) all 0; iteration counter and partial registers cleared. Reset mid-operation aborts silently; no done is issued.
- aluop encoding:
  - 0 SLL: y<<shamt
  - 1 SRA: y>>>shamt
  - 2 SRL: y>>shamt
  - 3 MULU
  - 4 DIVU
  - 5 ADD
  - 6 SUB
  - 7 AND
  - 8 OR
  - 9 XOR
  - 10 NOR
  - 11 SLT (signed)
  - 12 SLTU
  - 13 MUL (signed)
  - 14 DIV (signed)
  - 15 reserved → result=0
- ADD/SUB wrap modulo 2^WIDTH. SLT/SLTU give 1 or 0 zero-extended.
- Operand capture: x, y, shamt and aluop are registered on the accepting edge; later input changes have no effect.
- FSM states:
  - IDLE: start=1 with a single-cycle op → FIN; with op 3/4/13/14 → CALC with counter=WIDTH-1.
  - CALC: busy=1; one radix-2 step per cycle (shift-add multiply, restoring divide on magnitudes). Counter decrements; at counter=0 → FIN.
  - FIN: done=1, busy=0; result/result2/equal updated this cycle; unconditionally → IDLE.
- Latency (start accepted at edge 0):
  - Single-cycle ops: done at cycle 1.
  - Mul/div: busy cycles 1..WIDTH, done at cycle WIDTH+1.
- Back-to-back operation: start in FIN is ignored. Next acceptance is the following cycle in IDLE, so throughput is one op per 2 cycles minimum.
- start while CALC or FIN is ignored; no queuing.
- Outputs hold their values between done pulses until the next FIN.
- Signed mul/div: computed on magnitudes, then sign-fixed.
  - Product negative iff operand signs differ.
  - Quotient negative iff signs differ; remainder takes the dividend's sign.
- Division by zero (signed or unsigned): quotient = all-ones, remainder = x. Full latency still applies.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0.

Optional Feature:
- ALU_OVF_EN defined: adds output port ovf (1 bit, reset 0).
  - Updated in FIN: 1 for ADD/SUB signed overflow, 0 for all other ops.
- ALU_OVF_EN undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package seq_alu_pkg: aluop localparams (OP_SLL..OP_DIV), state enum typedef (IDLE/CALC/FIN), helper function is_iter(op).
- One sub-module, muldiv_iter: holds the counter, partial product/remainder, shifting, and sign fix-up.
  - Interface: load, op select, x, y → lo, hi, step-complete.
- seq_alu keeps the FSM, single-cycle ops and output registers.

Test Plan (WIDTH=32):
- ADD, x=32'h05010301, y=32'h52405760 → done at cycle 1, result=32'h57415A61, result2=0, equal=0. SUB with x=y=32'h1234 → result=0, equal=1.
- SLL y=32'h52405760 shamt=4 → 32'h24057600. SRA y=32'h80000000 shamt=31 → 32'hFFFFFFFF. SRL same → 32'h00000001.
- MULU x=32'hFFFFFFFF y=2 → busy cycles 1–32, done at 33, result=32'hFFFFFFFE, result2=32'h00000001. MUL x=-3 y=5 → result=32'hFFFFFFF1, result2=32'hFFFFFFFF.
- DIV x=-7 y=2 → result=32'hFFFFFFFD, result2=32'hFFFFFFFF. DIVU x=32'h1234 y=0 → result=32'hFFFFFFFF, result2=32'h00001234.
- start pulsed at cycles 5 and 32 during a MULU → ignored, single done at 33. rst_n low at cycle 10 of a DIV → all outputs 0 immediately, no done; new ADD after release completes normally.
- With ALU_OVF_EN: ADD 32'h7FFFFFFF+1 → ovf=1, result=32'h80000000. ADDU-range ADD 1+1 → ovf=0.
